// File: rtl/output_chunk_sender.sv
// ----------------------------------------------------------------------------
// output_chunk_sender
//
// Streams words from an activation memory (1-cycle read latency) onto a
// valid/ready link. Each word goes out LSB-first, as WIDTH-bit chunks or as
// SUBCHUNK_WIDTH-bit subchunks that are zero-extended to WIDTH. An optional
// single-chunk mode sends only chunk 0 of each word. These modes match the
// input chunk receiver, so a sender-to-receiver loopback rebuilds the words.
//
// Optional feature, enabled by the macro OUTPUT_CHUNK_SENDER_PREFETCH_EN:
// a second word buffer is filled with the next word while the current word
// is being sent. Words then follow each other with no bubble cycles. Without
// the macro, every word costs two bubble cycles (FETCH and LOAD).
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   enable                 global enable; low pauses FETCH and SEND
//   start                  begin a transfer (sampled in IDLE with enable high)
//   start_address          first word address
//   num_words              number of words to send, 0..NUM_ROWS
//   use_subchunks          send SUBCHUNK_WIDTH pieces, zero-extended
//   require_single_chunk   send only chunk 0 of each word
//   mem_read_enable        memory read strobe
//   mem_address            memory read address
//   mem_data_in            read data, valid the cycle after the strobe
//   data_out, data_valid   chunk payload and its valid flag
//   data_ready             receiver accepts; transfer on valid & ready
//   busy                   high in every state except IDLE
//   done                   one-cycle pulse after the last transfer
// ----------------------------------------------------------------------------
module output_chunk_sender #(
  parameter int NUM_ROWS                  = 32,
  parameter int WIDTH                     = 8,
  parameter int SUBCHUNK_WIDTH            = 4,
  parameter int ACTIVATION_WORD_BIT_WIDTH = 64,
  localparam int AddressBitWidth          = $clog2(NUM_ROWS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic                                 start,
  input  logic [AddressBitWidth-1:0]           start_address,
  input  logic [AddressBitWidth:0]             num_words,
  input  logic                                 use_subchunks,
  input  logic                                 require_single_chunk,
  output logic                                 mem_read_enable,
  output logic [AddressBitWidth-1:0]           mem_address,
  input  logic [ACTIVATION_WORD_BIT_WIDTH-1:0] mem_data_in,
  output logic [WIDTH-1:0]                     data_out,
  output logic                                 data_valid,
  input  logic                                 data_ready,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ChunksPerWord = ACTIVATION_WORD_BIT_WIDTH / WIDTH;
  localparam int SubsPerChunk  = WIDTH / SUBCHUNK_WIDTH;
  localparam int ChunkBits     = (ChunksPerWord > 1) ? $clog2(ChunksPerWord) : 1;
  localparam int SubBits       = (SubsPerChunk > 1) ? $clog2(SubsPerChunk) : 1;

  if (ACTIVATION_WORD_BIT_WIDTH % WIDTH != 0) begin : g_bad_word_width
    $fatal(1, "ACTIVATION_WORD_BIT_WIDTH must be a multiple of WIDTH");
  end
  if (WIDTH % SUBCHUNK_WIDTH != 0) begin : g_bad_subchunk_width
    $fatal(1, "SUBCHUNK_WIDTH must divide WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t                               state, state_next;
  logic [AddressBitWidth-1:0]           addr;
  logic [AddressBitWidth:0]             words_left;
  logic [ACTIVATION_WORD_BIT_WIDTH-1:0] shiftreg;
  logic [ChunkBits-1:0]                 chunk_count;
  logic [SubBits-1:0]                   sub_count;
  logic                                 cfg_sub;
  logic                                 cfg_single;

  logic [AddressBitWidth-1:0] next_addr;
  logic [ChunkBits-1:0]       last_chunk;
  logic                       last_piece;
  logic                       more_words;
  logic                       xfer;
  logic                       word_end;
  logic                       pf_issue;

  assign next_addr  = (addr == AddressBitWidth'(NUM_ROWS - 1)) ? '0
                                                               : addr + AddressBitWidth'(1);
  assign last_chunk = cfg_single ? '0 : ChunkBits'(ChunksPerWord - 1);
  // In chunk mode the subchunk counter stays at 0, so only the chunk
  // counter decides whether this is the last piece.
  assign last_piece = (chunk_count == last_chunk) &&
                      (!cfg_sub || sub_count == SubBits'(SubsPerChunk - 1));
  assign more_words = words_left > (AddressBitWidth + 1)'(1);
  assign xfer       = (state == SEND) && enable && data_ready;
  assign word_end   = xfer && last_piece;

`ifdef OUTPUT_CHUNK_SENDER_PREFETCH_EN
  logic [ACTIVATION_WORD_BIT_WIDTH-1:0] next_word;
  logic                                 pf_issued;   // next word already requested
  logic                                 pf_capture;  // read data is on mem_data_in now

  // The next word is requested on the first enabled SEND cycle of a word.
  assign pf_issue = (state == SEND) && enable && !pf_issued && more_words;
`else
  assign pf_issue = 1'b0;
`endif

  assign mem_read_enable = ((state == FETCH) && enable) || pf_issue;
  assign mem_address     = pf_issue ? next_addr : addr;
  assign data_out        = cfg_sub ? WIDTH'(shiftreg[SUBCHUNK_WIDTH-1:0])
                                   : shiftreg[WIDTH-1:0];
  assign data_valid      = (state == SEND) && enable;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && enable) state_next = (num_words != '0) ? FETCH : DONE;
      FETCH: if (enable) state_next = LOAD;
      LOAD:  state_next = SEND;
      SEND: begin
        if (word_end) begin
          if (!more_words) begin
            state_next = DONE;
          end else begin
`ifdef OUTPUT_CHUNK_SENDER_PREFETCH_EN
            // A one-piece word ends on the cycle its successor is requested;
            // LOAD then catches the read data with one bubble.
            state_next = pf_issue ? LOAD : SEND;
`else
            state_next = FETCH;
`endif
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      words_left  <= '0;
      shiftreg    <= '0;
      chunk_count <= '0;
      sub_count   <= '0;
      cfg_sub     <= 1'b0;
      cfg_single  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && enable) begin
            addr       <= start_address;
            words_left <= num_words;
            cfg_sub    <= use_subchunks;
            cfg_single <= require_single_chunk;
          end
        end
        LOAD: begin
          // Captured regardless of enable: the read data is only valid now.
          shiftreg    <= mem_data_in;
          chunk_count <= '0;
          sub_count   <= '0;
        end
        SEND: begin
          if (xfer) begin
            if (last_piece) begin
              words_left  <= words_left - (AddressBitWidth + 1)'(1);
              chunk_count <= '0;
              sub_count   <= '0;
              if (more_words) addr <= next_addr;
`ifdef OUTPUT_CHUNK_SENDER_PREFETCH_EN
              if (more_words && !pf_issue) shiftreg <= pf_capture ? mem_data_in : next_word;
`endif
            end else if (cfg_sub) begin
              shiftreg <= shiftreg >> SUBCHUNK_WIDTH;
              if (sub_count == SubBits'(SubsPerChunk - 1)) begin
                sub_count   <= '0;
                chunk_count <= chunk_count + ChunkBits'(1);
              end else begin
                sub_count <= sub_count + SubBits'(1);
              end
            end else begin
              shiftreg    <= shiftreg >> WIDTH;
              chunk_count <= chunk_count + ChunkBits'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OUTPUT_CHUNK_SENDER_PREFETCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_word  <= '0;
      pf_issued  <= 1'b0;
      pf_capture <= 1'b0;
    end else begin
      pf_capture <= pf_issue;
      if (pf_capture) next_word <= mem_data_in;
      if (word_end || state == IDLE) pf_issued <= 1'b0;
      else if (pf_issue)             pf_issued <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_output_chunk_sender.sv
// ----------------------------------------------------------------------------
// tb_output_chunk_sender
//
// Directed bench for output_chunk_sender. A behavioural memory answers reads
// one cycle after the strobe. Expected pieces are computed from the memory
// contents and pushed to a scoreboard queue when each transfer is started; a
// monitor on the falling edge pops and compares each accepted piece.
// ----------------------------------------------------------------------------
module tb_output_chunk_sender;

  localparam int NumRows = 32;
  localparam int Width   = 8;
  localparam int SubW    = 4;
  localparam int WordW   = 64;
  localparam int Abw     = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             start = 1'b0;
  logic [Abw-1:0]   start_address = '0;
  logic [Abw:0]     num_words = '0;
  logic             use_subchunks = 1'b0;
  logic             require_single_chunk = 1'b0;
  logic             mem_read_enable;
  logic [Abw-1:0]   mem_address;
  logic [WordW-1:0] mem_data_in;
  logic [Width-1:0] data_out;
  logic             data_valid;
  logic             data_ready = 1'b1;
  logic             busy;
  logic             done;

  output_chunk_sender dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .enable               (enable),
    .start                (start),
    .start_address        (start_address),
    .num_words            (num_words),
    .use_subchunks        (use_subchunks),
    .require_single_chunk (require_single_chunk),
    .mem_read_enable      (mem_read_enable),
    .mem_address          (mem_address),
    .mem_data_in          (mem_data_in),
    .data_out             (data_out),
    .data_valid           (data_valid),
    .data_ready           (data_ready),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  logic [WordW-1:0] mem [NumRows];
  always @(posedge clk) if (mem_read_enable) mem_data_in <= mem[mem_address];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [Width-1:0] sb[$];
  int               done_count = 0;
  int               read_count = 0;
  int               valid_count = 0;
  int               first_x = -1;
  int               last_x = -1;
  logic             prev_stall = 1'b0;
  logic [Width-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (done) done_count++;
    if (mem_read_enable) read_count++;
    if (data_valid) valid_count++;
    if (prev_stall && data_valid) check("stall_stable", 64'(data_out), 64'(prev_data));
    if (data_valid && data_ready) begin
      if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
      else                check("piece", 64'(data_out), 64'(sb.pop_front()));
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    prev_stall = data_valid && !data_ready;
    prev_data  = data_out;
  end

  task automatic push_expected(input int sa, input int nw, input bit sub, input bit single);
    for (int w = 0; w < nw; w++) begin
      logic [WordW-1:0] word;
      int               np;
      word = mem[(sa + w) % NumRows];
      np   = sub ? (single ? Width / SubW : WordW / SubW) : (single ? 1 : WordW / Width);
      for (int i = 0; i < np; i++) begin
        if (sub) sb.push_back(Width'(word[i*SubW +: SubW]));
        else     sb.push_back(word[i*Width +: Width]);
      end
    end
  endtask

  // Starts one transfer and runs it to done. Called at posedge+#1.
  task automatic run(input string tag, input int sa, input int nw, input bit sub,
                     input bit single, input bit rnd, input int pause_at,
                     output int span, output int iters);
    push_expected(sa, nw, sub, single);
    done_count  = 0;
    read_count  = 0;
    valid_count = 0;
    first_x     = -1;
    last_x      = -1;
    start_address        = Abw'(sa);
    num_words            = (Abw + 1)'(nw);
    use_subchunks        = sub;
    require_single_chunk = single;
    start                = 1'b1;
    @(posedge clk); #1;
    // Scramble the configuration inputs; the DUT must have latched them.
    start                = 1'b0;
    start_address        = Abw'(sa + 7);
    num_words            = (Abw + 1)'(3);
    use_subchunks        = !sub;
    require_single_chunk = !single;
    iters = 0;
    for (int i = 0; i < 3000 && done_count == 0; i++) begin
      enable     = !(pause_at >= 0 && i >= pause_at && i < pause_at + 3);
      data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = (i == 2);   // start while busy must be ignored
      @(posedge clk); #1;
      iters++;
    end
    start      = 1'b0;
    enable     = 1'b1;
    data_ready = 1'b1;
    check({tag, "_done"}, 64'(done_count), 64'd1);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_once"}, 64'(done_count), 64'd1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
    span = last_x - first_x + 1;
  endtask

  int span;
  int iters;
  int exp_span;

  initial begin
    for (int i = 0; i < NumRows; i++) mem[i] = {$urandom, $urandom};
    mem[0]  = 64'h0807060504030201;
    mem[30] = 64'h1122334455667730;
    mem[31] = 64'h99AABBCCDDEEFF31;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_read_enable", 64'(mem_read_enable), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_data_valid", 64'(data_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;

    // Single word, chunk mode: 8 consecutive chunks
    run("t1", 0, 1, 1'b0, 1'b0, 1'b0, -1, span, iters);
    check("t1_span", 64'(span), 64'd8);
    check("t1_reads", 64'(read_count), 64'd1);

    // Single word, subchunk mode: 16 consecutive subchunks
    run("t2", 0, 1, 1'b1, 1'b0, 1'b0, -1, span, iters);
    check("t2_span", 64'(span), 64'd16);

    // Single-chunk mode with address wrap 30, 31, 0
    run("t3", 30, 3, 1'b0, 1'b1, 1'b0, -1, span, iters);
    check("t3_reads", 64'(read_count), 64'd3);
    check("t3_valid_xfers", 64'(first_x >= 0), 64'd1);

    // Random back-pressure plus an enable pause, both modes
    run("t4a", 5, 3, 1'b0, 1'b0, 1'b1, 12, span, iters);
    run("t4b", 10, 2, 1'b1, 1'b0, 1'b1, 7, span, iters);
    run("t4c", 29, 4, 1'b1, 1'b1, 1'b1, 5, span, iters);

    // Zero words: done only, no reads and no data
    run("t5a", 4, 0, 1'b0, 1'b0, 1'b0, -1, span, iters);
    check("t5a_reads", 64'(read_count), 64'd0);
    check("t5a_valids", 64'(valid_count), 64'd0);
    check("t5a_latency", 64'(iters <= 2), 64'd1);

    // Reset in the middle of SEND
    push_expected(0, 4, 1'b0, 1'b0);
    done_count    = 0;
    start_address = '0;
    num_words     = (Abw + 1)'(4);
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && !data_valid; i++) begin
      @(posedge clk); #1;
    end
    check("t5b_reached_send", 64'(data_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5b_rst_valid", 64'(data_valid), 64'd0);
    check("t5b_rst_busy", 64'(busy), 64'd0);
    check("t5b_rst_done", 64'(done), 64'd0);
    check("t5b_rst_read", 64'(mem_read_enable), 64'd0);
    check("t5b_rst_data", 64'(data_out), 64'd0);
    check("t5b_rst_addr", 64'(mem_address), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5b_no_partial_done", 64'(done_count), 64'd0);
    run("t5c", 3, 2, 1'b0, 1'b0, 1'b0, -1, span, iters);
`ifdef OUTPUT_CHUNK_SENDER_PREFETCH_EN
    exp_span = 16;
`else
    exp_span = 18;
`endif
    check("t5c_span", 64'(span), 64'(exp_span));

    // Four-word stream throughput
    run("t6", 0, 4, 1'b0, 1'b0, 1'b0, -1, span, iters);
`ifdef OUTPUT_CHUNK_SENDER_PREFETCH_EN
    exp_span = 32;
`else
    exp_span = 38;
`endif
    check("t6_span", 64'(span), 64'(exp_span));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
